// File: rtl/hub75_scanner.sv
// HUB75 read-side scanner: walks the display bank, shifts one
// bit-plane per row pass and shows it with binary code modulation.
module hub75_scanner #(
  parameter int BITS_PER_PIXEL = 12,
  parameter int PANEL_WIDTH    = 64,
  parameter int PANEL_ROWS     = 16,
  parameter int BASE_CYCLES    = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic [$clog2(PANEL_ROWS)+$clog2(PANEL_WIDTH)-1:0] read_addr,
  output logic read_en,
  input  logic [BITS_PER_PIXEL-1:0] read_data_top,
  input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
  output logic hub75_r0,
  output logic hub75_g0,
  output logic hub75_b0,
  output logic hub75_r1,
  output logic hub75_g1,
  output logic hub75_b1,
  output logic hub75_clk,
  output logic hub75_latch,
  output logic hub75_oe_n,
  output logic [$clog2(PANEL_ROWS)-1:0] hub75_row,
  output logic frame_done
);

  localparam int BPC   = BITS_PER_PIXEL / 3;
  localparam int COL_W = $clog2(PANEL_WIDTH);
  localparam int ROW_W = $clog2(PANEL_ROWS);
  localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CNT_W = $clog2((BASE_CYCLES << (BPC - 1)) + 1);
  localparam int IDX_W = $clog2(BITS_PER_PIXEL);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(PANEL_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(PANEL_ROWS - 1);
  localparam logic [PL_W-1:0]  LAST_PLANE = PL_W'(BPC - 1);

  typedef enum logic [2:0] {
    SHIFT_ADDR,
    SHIFT_DATA,
    SHIFT_CLK,
    BLANK,
    LATCH,
    UNLATCH,
    DISPLAY
  } state_t;

  state_t state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PL_W-1:0]  plane_q, plane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  logic [IDX_W-1:0] r_idx, g_idx, b_idx;
  logic [5:0]       rgb_now, rgb_q;

  logic             en_q;
  logic             sclk_q;
  logic             latch_q;
  logic             oe_n_q;
  logic [ROW_W-1:0] row_out_q;
  logic             fd_q;

  // Select the current bit-plane from each colour field
  assign b_idx = IDX_W'(plane_q);
  assign g_idx = IDX_W'(BPC) + IDX_W'(plane_q);
  assign r_idx = IDX_W'(2 * BPC) + IDX_W'(plane_q);

  assign rgb_now = {
    read_data_top[r_idx],
    read_data_top[g_idx],
    read_data_top[b_idx],
    read_data_bottom[r_idx],
    read_data_bottom[g_idx],
    read_data_bottom[b_idx]
  };

  // Next-state and counter advance
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    unique case (state_q)
      SHIFT_ADDR: state_d = SHIFT_DATA;
      SHIFT_DATA: state_d = SHIFT_CLK;
      SHIFT_CLK: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = SHIFT_ADDR;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: state_d = UNLATCH;
      UNLATCH: begin
        cnt_d   = CNT_W'(BASE_CYCLES) << plane_q;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = SHIFT_ADDR;
          if (plane_q == LAST_PLANE) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
            wrap    = (row_q == LAST_ROW);
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = SHIFT_ADDR;
    endcase
  end

  // State and scan position registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SHIFT_ADDR;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
    end
  end

  // Panel controls registered from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      oe_n_q    <= 1'b1;
      row_out_q <= '0;
      fd_q      <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      sclk_q  <= (state_d == SHIFT_CLK);
      latch_q <= (state_d == LATCH);
      oe_n_q  <= (state_d != DISPLAY);
      fd_q    <= wrap;
      if (state_d == LATCH) begin
        row_out_q <= row_q;
      end
    end
  end

  // Hold the shifted pixel bits through the shift-clock high phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else if (state_q == SHIFT_DATA) begin
      rgb_q <= rgb_now;
    end
  end

  assign read_addr   = {row_q, col_q};
  assign read_en     = en_q;
  assign hub75_clk   = sclk_q;
  assign hub75_latch = latch_q;
  assign hub75_oe_n  = oe_n_q;
  assign hub75_row   = row_out_q;
  assign frame_done  = fd_q;

  assign {hub75_r0, hub75_g0, hub75_b0,
          hub75_r1, hub75_g1, hub75_b1} =
    (state_q == SHIFT_DATA) ? rgb_now : rgb_q;

endmodule

// File: doc/hub75_scanner.md
Name: hub75_scanner

Overview:
- Read-side engine of the HUB75 controller.
- Continuously scans the display half of the dual-bank pixel RAM. Each read returns the top-half and bottom-half pixels together.
- Drives HUB75 panel pins (RGB data, shift clock, latch, output-enable, row address) using binary code modulation (BCM) over the colour bit-planes.
- Emits a one-cycle frame_done pulse at the end of each full frame; the top level uses it to flip the RAM buffer_toggle.

Parameters:
BITS_PER_PIXEL, 12, pixel width; packed {R,G,B}, each BITS_PER_PIXEL/3 bits (BPC), MSB-first per colour
PANEL_WIDTH, 64, pixels per row; read_addr[5:0] column
PANEL_ROWS, 16, scan rows per half; read_addr[9:6] and row_addr
BASE_CYCLES, 4, display cycles for bit-plane 0; plane p displays BASE_CYCLES<<p cycles

Ports:
clk  input  1  system clock; also the RAM read_clk
reset_n  input  1  asynchronous active-low reset
read_addr  output  10  RAM read address {row[3:0], col[5:0]}
read_en  output  1  RAM read enable
read_data_top  input  BITS_PER_PIXEL  RAM data for rows 0-15, valid one clk after address
read_data_bottom  input  BITS_PER_PIXEL  RAM data for rows 16-31, same timing
hub75_r0, hub75_g0, hub75_b0  output  1 each  top-half colour bits
hub75_r1, hub75_g1, hub75_b1  output  1 each  bottom-half colour bits
hub75_clk  output  1  panel shift clock; panel samples on rising edge
hub75_latch  output  1  panel latch, active high
hub75_oe_n  output  1  panel output enable, active low
hub75_row  output  4  panel row address (A-D)
frame_done  output  1  one-clk pulse after last plane of last row

Behaviour:
- Reset (async assert, sync release): read_addr=0, read_en=0, all RGB=0, hub75_clk=0, hub75_latch=0, hub75_oe_n=1, hub75_row=0, frame_done=0; internal col=0, row=0, plane=0; state=SHIFT_ADDR. Reset mid-frame aborts immediately with no partial latch.
- read_en=1 in every cycle after reset release. It never drops, so RAM outputs never tristate.
- State machine:
  - SHIFT_ADDR: read_addr={row,col}; hub75_clk=0 -> SHIFT_DATA.
  - SHIFT_DATA: RAM data valid; register it. r0=top[2*BPC+plane], g0=top[BPC+plane], b0=top[plane]; r1/g1/b1 same bits from bottom. hub75_clk=0 -> SHIFT_CLK.
  - SHIFT_CLK: hub75_clk=1, RGB held. If col==PANEL_WIDTH-1: col=0 -> BLANK. Else col++ -> SHIFT_ADDR.
  - BLANK: hub75_clk=0, hub75_oe_n=1 -> LATCH.
  - LATCH: hub75_latch=1, hub75_row=row -> UNLATCH.
  - UNLATCH: hub75_latch=0, load display counter with BASE_CYCLES<<plane -> DISPLAY.
  - DISPLAY: hub75_oe_n=0 for exactly BASE_CYCLES<<plane cycles. Then hub75_oe_n=1 and advance:
    - if plane==BPC-1: plane=0, row++;
    - else plane++.
    - -> SHIFT_ADDR.
  - Row wrap: when row advances from PANEL_ROWS-1 to 0, frame_done=1 for exactly one cycle, coincident with the first SHIFT_ADDR of the new frame.
- Per pixel: 3 clks, so hub75_clk runs at clk/3 with high time 1 clk. RGB is stable one clk before and during the rising edge.
- Per plane: PANEL_WIDTH*3 + 3 + (BASE_CYCLES<<plane) clks. No overlap of shifting with display.
- hub75_oe_n is never 0 while hub75_latch=1 or hub75_row is changing.
- Display counter width: enough for BASE_CYCLES<<(BPC-1). Row and col wrap naturally at power-of-two sizes.

Test Plan:
- Reset release, all-zero RAM -> read_en=1 on the first clk. 64 hub75_clk rising edges with all RGB=0, then latch pulse 1 clk, then oe_n low exactly 4 clks, hub75_row=0.
- Top pixel (row 0, col 5)=12'hF00, all else 0 -> during plane 0..3, r0=1 only at the 6th hub75_clk rise; g0/b0/r1/g1/b1 stay 0. Display lengths 4, 8, 16, 32 clks.
- Bottom pixel (row 3, col 63)=12'h00A -> b1=1 on the 64th shift of planes 1 and 3 only, with hub75_row=3 at that latch.
- Count clks between frame_done pulses -> 13440 (16 rows × (4×195 + 60)). Exactly 64 hub75_clk edges per latch. oe_n never low while latch=1.
- Assert reset_n low during DISPLAY of row 7 plane 2 -> outputs take reset values asynchronously. After release, scanning restarts at row 0 plane 0 col 0.
- Sample read_addr across one frame -> sequence {row,col} increments per 3 clks. read_en never 0. RAM data is captured exactly one clk after the address.
